seq_detector: RTL and testbench
===============================

SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width in bits (legal 2..32).
REQ-003 SHALL have parameter PAT_RST, default 4'b1011 (PAT_LEN bits), pattern value loaded at reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port x_valid  input  1  qualifies x this cycle.
REQ-007 SHALL have port x  input  1  serial data bit.
REQ-008 SHALL have port overlap  input  1  1 = overlapping matches counted; 0 = non-overlapping.
REQ-009 SHALL have port pat_load  input  1  load pat_in as new pattern.
REQ-010 SHALL have port pat_in  input  PAT_LEN  new pattern, bit 0 = newest (last-received) bit.
REQ-011 SHALL have port state  output  2  current FSM state (registered).
REQ-012 SHALL have port z_mealy  output  1  combinational match indication.
REQ-013 SHALL have port z_moore  output  1  registered match indication.
REQ-014 SHALL have port match_cnt  output  CNT_W  saturating number of matches.
REQ-015 SHALL have port cnt_sat  output  1  high while match_cnt is all-ones.

Function
REQ-016 SHALL hold a PAT_LEN-bit history register hist; on accepted x (x_valid=1, pat_load=0) hist <= {hist[PAT_LEN-2:0], x}; otherwise hist holds.
REQ-017 SHALL keep fill, count of valid history bits, 0..PAT_LEN-1, incrementing by 1 per accepted bit, saturating at PAT_LEN-1.
REQ-018 SHALL define states IDLE=0 (fill=0), FILL=1 (0<fill<PAT_LEN-1), ARMED=2 (fill=PAT_LEN-1); encoding 3 unused, SHALL recover to IDLE next cycle.
REQ-019 SHALL define hit = x_valid & !pat_load & (state==ARMED) & ({hist[PAT_LEN-2:0], x} == pattern).
REQ-020 SHALL drive z_mealy = hit combinationally, same cycle as x (zero latency).
REQ-021 SHALL drive z_moore <= hit, i.e. one cycle after z_mealy, high for exactly one cycle per hit.
REQ-022 On hit with overlap=1, SHALL remain in ARMED (fill unchanged).
REQ-023 On hit with overlap=0, SHALL set fill to 0 and state to IDLE next cycle; the matched bits SHALL NOT contribute to a later match.
REQ-024 overlap SHALL be sampled only in the hit cycle; changing it mid-stream affects the next hit only.
REQ-025 On hit, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1; it SHALL never wrap.
REQ-026 cnt_sat SHALL equal (match_cnt == all-ones), registered with match_cnt.
REQ-027 On pat_load=1: pattern <= pat_in, fill <= 0, state <= IDLE, match_cnt <= 0, z_moore <= 0; same-cycle x is ignored and z_mealy SHALL be 0 (load has priority).
REQ-028 Cycles with x_valid=0 SHALL not alter hist, fill, state or match_cnt; z_moore SHALL fall to 0.

Reset
REQ-029 When rst_n=0 at a rising clk edge: hist=0, fill=0, state=IDLE, pattern=PAT_RST, z_moore=0, match_cnt=0, cnt_sat=0.
REQ-030 Reset SHALL take priority over pat_load and x_valid; z_mealy SHALL be 0 while rst_n=0.
REQ-031 Reset asserted mid-stream SHALL discard partial history; the first hit after release requires PAT_LEN fresh accepted bits.

Structure
REQ-032 State encoding enum and legal PAT_LEN/CNT_W bounds SHALL live in shared package seq_det_pkg.
REQ-033 The saturating counter SHALL be a sub-module sat_counter (parameter W; inputs clk, rst_n, clr, inc; outputs cnt, sat).
REQ-034 No storage beyond hist, pattern, fill/state, z_moore and counter.

Verification (PAT_LEN=4, pattern 1011, oldest bit first)
REQ-035 Reset: hold rst_n=0 two cycles with x_valid=1 -> state=0, z_moore=0, match_cnt=0, cnt_sat=0, z_mealy=0.
REQ-036 overlap=1, stream 1,0,1,1,0,1,1 -> z_mealy on bits 4 and 7, z_moore one cycle later each, match_cnt=2.
REQ-037 overlap=0, same stream -> z_mealy on bit 4 only, state IDLE after it, match_cnt=1.
REQ-038 Stream 1,0,1,1 with x_valid=0 gaps of 3 cycles between bits -> single hit on 4th valid bit, counters unchanged during gaps.
REQ-039 CNT_W=2, overlap=1, stream 1011 repeated via 1,0,1,1,0,1,1,0,1,1,0,1,1 -> match_cnt=3, cnt_sat=1 after 3rd hit, stays 3 after 4th.
REQ-040 pat_load=1 with pat_in=0110 in the cycle a 1011 hit would occur -> z_mealy=0, match_cnt=0, then stream 0,1,1,0 -> hit on 4th bit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding and
// legal parameter ranges.
package seq_det_pkg;

  localparam int unsigned PAT_LEN_MIN = 2;
  localparam int unsigned PAT_LEN_MAX = 16;
  localparam int unsigned CNT_W_MIN   = 2;
  localparam int unsigned CNT_W_MAX   = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2,
    S_BAD   = 2'd3
  } state_e;

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered all-ones flag.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_d, cnt_q;
  logic         sat_d, sat_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat_q) begin
      cnt_d = cnt_q + 1'b1;
    end
    sat_d = &cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with loadable pattern, overlap control, Mealy and
// Moore match outputs and a saturating match counter.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned          PAT_LEN = 4,
  parameter int unsigned          CNT_W   = 8,
  parameter logic [PAT_LEN-1:0]   PAT_RST = 4'b1011
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x_valid,
  input  logic               x,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic [1:0]         state,
  output logic               z_mealy,
  output logic               z_moore,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int unsigned FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX ||
      CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_param
    $error("seq_detector: PAT_LEN or CNT_W out of range");
  end

  // The oldest history bit is shifted out before it can take part in a
  // compare, so only the newest PAT_LEN-1 bits are kept.
  logic [PAT_LEN-2:0]  hist_d, hist_q;
  logic [PAT_LEN-1:0]  pat_d, pat_q;
  logic [FILL_W-1:0]   fill_d, fill_q;
  state_e              state_d, state_q;
  logic                z_moore_d, z_moore_q;
  logic                accept;
  logic                hit;
  logic [PAT_LEN-1:0]  shifted;

  always_comb begin
    accept    = x_valid & ~pat_load;
    shifted   = {hist_q, x};
    hit       = rst_n & accept & (state_q == S_ARMED) & (shifted == pat_q);

    hist_d    = hist_q;
    pat_d     = pat_q;
    fill_d    = fill_q;
    state_d   = state_q;
    z_moore_d = hit;

    if (accept) begin
      hist_d = shifted[PAT_LEN-2:0];
    end

    if (pat_load) begin
      pat_d   = pat_in;
      fill_d  = '0;
      state_d = S_IDLE;
    end else if (state_q == S_BAD) begin
      fill_d  = '0;
      state_d = S_IDLE;
    end else if (x_valid) begin
      if (hit) begin
        if (!overlap) begin
          fill_d = '0;
        end
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
      if (fill_d == '0) begin
        state_d = S_IDLE;
      end else if (fill_d == FILL_MAX) begin
        state_d = S_ARMED;
      end else begin
        state_d = S_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q    <= '0;
      pat_q     <= PAT_RST;
      fill_q    <= '0;
      state_q   <= S_IDLE;
      z_moore_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      pat_q     <= pat_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      z_moore_q <= z_moore_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pat_load),
    .inc   (hit),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

  assign state   = state_q;
  assign z_mealy = hit;
  assign z_moore = z_moore_q;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: vector table plus hand-built multi-cycle
// sequences (gaps, mid-stream reset, counter saturation on a narrow instance).
module tb_seq_detector;

  logic       clk;
  logic       rst_n;
  logic       x_valid;
  logic       x;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;

  logic [1:0] state,  s_state;
  logic       z_mealy, s_mealy;
  logic       z_moore, s_moore;
  logic [7:0] match_cnt;
  logic [1:0] s_cnt;
  logic       cnt_sat, s_sat;

  int n_chk  = 0;
  int n_pass = 0;

  seq_detector #(.PAT_LEN(4), .CNT_W(8), .PAT_RST(4'b1011)) dut (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .state(state), .z_mealy(z_mealy),
    .z_moore(z_moore), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector #(.PAT_LEN(4), .CNT_W(2), .PAT_RST(4'b1011)) dut_sat (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .state(s_state), .z_mealy(s_mealy),
    .z_moore(s_moore), .match_cnt(s_cnt), .cnt_sat(s_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, xv, x, ovl, load;
    logic [3:0] pin;
    logic       mealy;
    logic [1:0] st;
    logic       moore;
    logic [7:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, xv_i, x_i, o, l, input logic [3:0] p,
                              input logic m, input logic [1:0] s, input logic mo,
                              input logic [7:0] c);
    vec_t v;
    v.rst_n = r; v.xv = xv_i; v.x = x_i; v.ovl = o; v.load = l; v.pin = p;
    v.mealy = m; v.st = s; v.moore = mo; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Drive one cycle, check z_mealy before the edge, registered outputs after it.
  task automatic apply(input vec_t v, input string tag);
    rst_n = v.rst_n; x_valid = v.xv; x = v.x; overlap = v.ovl;
    pat_load = v.load; pat_in = v.pin;
    #1;
    chk({tag, " z_mealy"}, 32'(z_mealy), 32'(v.mealy));
    @(posedge clk);
    #1;
    chk({tag, " state"},     32'(state),     32'(v.st));
    chk({tag, " z_moore"},   32'(z_moore),   32'(v.moore));
    chk({tag, " match_cnt"}, 32'(match_cnt), 32'(v.cnt));
    chk({tag, " cnt_sat"},   32'(cnt_sat),   32'(v.cnt == 8'hFF));
  endtask

  vec_t tbl[$];

  initial begin
    logic [3:0]  gap_bits;
    logic [12:0] sat_bits;
    logic [1:0]  exp_st;
    logic [7:0]  exp_cnt;
    logic [1:0]  exp_scnt;
    logic        m;

    rst_n = 1'b0; x_valid = 1'b0; x = 1'b0; overlap = 1'b0;
    pat_load = 1'b0; pat_in = '0;

    // reset held with x_valid high
    tbl.push_back(mk(0,1,1,1,0,4'h0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 0,0,0,0));
    // overlap=1: 1,0,1,1,0,1,1
    tbl.push_back(mk(1,1,1,1,0,4'h0, 0,1,0,0));
    tbl.push_back(mk(1,1,0,1,0,4'h0, 0,1,0,0));
    tbl.push_back(mk(1,1,1,1,0,4'h0, 0,2,0,0));
    tbl.push_back(mk(1,1,1,1,0,4'h0, 1,2,1,1));
    tbl.push_back(mk(1,1,0,1,0,4'h0, 0,2,0,1));
    tbl.push_back(mk(1,1,1,1,0,4'h0, 0,2,0,1));
    tbl.push_back(mk(1,1,1,1,0,4'h0, 1,2,1,2));
    tbl.push_back(mk(1,0,0,1,0,4'h0, 0,2,0,2));
    tbl.push_back(mk(0,1,1,0,0,4'h0, 0,0,0,0));
    // overlap=0: same stream
    tbl.push_back(mk(1,1,1,0,0,4'h0, 0,1,0,0));
    tbl.push_back(mk(1,1,0,0,0,4'h0, 0,1,0,0));
    tbl.push_back(mk(1,1,1,0,0,4'h0, 0,2,0,0));
    tbl.push_back(mk(1,1,1,0,0,4'h0, 1,0,1,1));
    tbl.push_back(mk(1,1,0,0,0,4'h0, 0,1,0,1));
    tbl.push_back(mk(1,1,1,0,0,4'h0, 0,1,0,1));
    tbl.push_back(mk(1,1,1,0,0,4'h0, 0,2,0,1));
    // walk history to ...101 so the next 1 would hit, then load instead
    tbl.push_back(mk(1,1,0,0,0,4'h0, 0,2,0,1));
    tbl.push_back(mk(1,1,1,0,0,4'h0, 0,2,0,1));
    tbl.push_back(mk(1,1,1,0,1,4'h6, 0,0,0,0));
    // new pattern 0110
    tbl.push_back(mk(1,1,0,0,0,4'h0, 0,1,0,0));
    tbl.push_back(mk(1,1,1,0,0,4'h0, 0,1,0,0));
    tbl.push_back(mk(1,1,1,0,0,4'h0, 0,2,0,0));
    tbl.push_back(mk(1,1,0,0,0,4'h0, 1,0,1,1));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 0,0,0,1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // mid-stream reset: partial 101 discarded, pattern back to 1011
    apply(mk(1,1,1,1,0,4'h0, 0,1,0,1), "mrst a");
    apply(mk(1,1,0,1,0,4'h0, 0,1,0,1), "mrst b");
    apply(mk(1,1,1,1,0,4'h0, 0,2,0,1), "mrst c");
    apply(mk(0,0,0,1,0,4'h0, 0,0,0,0), "mrst rst");
    apply(mk(1,1,1,1,0,4'h0, 0,1,0,0), "mrst d");
    apply(mk(1,1,0,1,0,4'h0, 0,1,0,0), "mrst e");
    apply(mk(1,1,1,1,0,4'h0, 0,2,0,0), "mrst f");
    apply(mk(1,1,1,1,0,4'h0, 1,2,1,1), "mrst g");

    // x_valid gaps of 3 cycles between bits of 1011, with x toggling
    apply(mk(0,0,0,1,0,4'h0, 0,0,0,0), "gap rst");
    gap_bits = 4'b1011;
    exp_cnt  = 8'd0;
    for (int b = 0; b < 4; b++) begin
      exp_st = (b < 2) ? 2'd1 : 2'd2;
      m      = (b == 3);
      if (m) exp_cnt = 8'd1;
      apply(mk(1,1,gap_bits[3-b],1,0,4'h0, m,exp_st,m,exp_cnt), $sformatf("gap bit%0d", b));
      for (int g = 0; g < 3; g++)
        apply(mk(1,0,~gap_bits[3-b],1,0,4'h0, 0,exp_st,0,exp_cnt),
              $sformatf("gap bit%0d idle%0d", b, g));
    end

    // narrow counter saturation: hits on bits 4,7,10,13
    apply(mk(0,0,0,1,0,4'h0, 0,0,0,0), "sat rst");
    chk("sat rst cnt", 32'(s_cnt), 0);
    chk("sat rst flag", 32'(s_sat), 0);
    sat_bits = 13'b1011011011011;
    exp_cnt  = 8'd0;
    exp_scnt = 2'd0;
    for (int b = 0; b < 13; b++) begin
      m      = (b >= 3) && (b % 3 == 0);
      exp_st = (b < 2) ? 2'd1 : 2'd2;
      if (m) begin
        exp_cnt = exp_cnt + 8'd1;
        if (exp_scnt != 2'd3) exp_scnt = exp_scnt + 2'd1;
      end
      apply(mk(1,1,sat_bits[12-b],1,0,4'h0, m,exp_st,m,exp_cnt), $sformatf("sat bit%0d", b));
      chk($sformatf("sat bit%0d narrow cnt", b), 32'(s_cnt), 32'(exp_scnt));
      chk($sformatf("sat bit%0d narrow flag", b), 32'(s_sat), 32'(exp_scnt == 2'd3));
    end
    chk("sat final narrow cnt", 32'(s_cnt), 3);
    chk("sat final wide cnt", 32'(match_cnt), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
